// File: rtl/shift_reg_pkg.sv
// Shared operation codes and shift-direction constants for the universal shift register.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD      = 2'b00,
        MODE_SHIFT     = 2'b01,
        MODE_PARA_LOAD = 2'b10,
        MODE_ROTATE    = 2'b11
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// Saturating 0..WIDTH count of bits shifted out since the last parallel load.
// Resets to WIDTH so that a freshly reset register reads as empty.
module shift_bit_counter #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = (r_cnt == CNT_MAX);

    // clr has priority over inc so a load restarts the count with no carry-over
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= CNT_MAX;
        end else if (ENB) begin
            if (clr) begin
                r_cnt <= '0;
            end else if (inc && !w_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cnt = r_cnt;
    assign sat = w_sat;

endmodule

// File: rtl/univ_shift_reg_n.sv
// WIDTH-bit universal shift register: hold, serial shift, parallel load, optional rotate.
// Rotate is built only when UNIV_SHIFT_ROTATE_EN is defined; otherwise MODO=2'b11 holds.
module univ_shift_reg_n
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic [CNT_W-1:0] BIT_CNT,
    output logic             EMPTY
);

    mode_e            w_mode;
    logic [WIDTH-1:0] r_q;
    logic             r_s_out;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_s_out_nxt;
    logic             w_clr;
    logic             w_inc;
    logic [CNT_W-1:0] w_cnt;
    logic             w_sat;

    assign w_mode = mode_e'(MODO);

    always_comb begin
        w_q_nxt     = r_q;
        w_s_out_nxt = r_s_out;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        if (ENB) begin
            case (w_mode)
                MODE_SHIFT: begin
                    w_inc = 1'b1;
                    if (DIR == DIR_LEFT) begin
                        w_q_nxt     = {r_q[WIDTH-2:0], S_IN};
                        w_s_out_nxt = r_q[WIDTH-1];
                    end else begin
                        w_q_nxt     = {S_IN, r_q[WIDTH-1:1]};
                        w_s_out_nxt = r_q[0];
                    end
                end
                MODE_PARA_LOAD: begin
                    w_q_nxt = D;
                    w_clr   = 1'b1;
                end
`ifdef UNIV_SHIFT_ROTATE_EN
                // no data leaves the register, so the bit count is left alone
                MODE_ROTATE: begin
                    if (DIR == DIR_LEFT) begin
                        w_q_nxt     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                        w_s_out_nxt = r_q[WIDTH-1];
                    end else begin
                        w_q_nxt     = {r_q[0], r_q[WIDTH-1:1]};
                        w_s_out_nxt = r_q[0];
                    end
                end
`else
                MODE_ROTATE: begin
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q     <= '0;
            r_s_out <= 1'b0;
        end else begin
            r_q     <= w_q_nxt;
            r_s_out <= w_s_out_nxt;
        end
    end

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .CLK (CLK),
        .RST (RST),
        .ENB (ENB),
        .clr (w_clr),
        .inc (w_inc),
        .cnt (w_cnt),
        .sat (w_sat)
    );

    assign Q       = r_q;
    assign S_OUT   = r_s_out;
    assign BIT_CNT = w_cnt;
    assign EMPTY   = w_sat;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Scoreboard bench for univ_shift_reg_n at WIDTH=4 and WIDTH=8.
// Expected rotate behaviour follows UNIV_SHIFT_ROTATE_EN.
module tb_univ_shift_reg_n;

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       so;
        logic [3:0] cnt;
        logic       empty;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, enb4 = 1'b0, dir4 = 1'b0, sin4 = 1'b0;
    logic [1:0] modo4 = 2'b00;
    logic [3:0] d4 = '0;
    logic [3:0] q_4;
    logic       so_4, empty_4;
    logic [2:0] cnt_4;

    logic       rst8 = 1'b1, enb8 = 1'b0, dir8 = 1'b0, sin8 = 1'b0;
    logic [1:0] modo8 = 2'b00;
    logic [7:0] d8 = '0;
    logic [7:0] q_8;
    logic       so_8, empty_8;
    logic [3:0] cnt_8;

    univ_shift_reg_n #(.WIDTH(4)) dut4 (
        .CLK(clk), .RST(rst4), .ENB(enb4), .DIR(dir4), .S_IN(sin4), .MODO(modo4),
        .D(d4), .Q(q_4), .S_OUT(so_4), .BIT_CNT(cnt_4), .EMPTY(empty_4)
    );

    univ_shift_reg_n #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst8), .ENB(enb8), .DIR(dir8), .S_IN(sin8), .MODO(modo8),
        .D(d8), .Q(q_8), .S_OUT(so_8), .BIT_CNT(cnt_8), .EMPTY(empty_8)
    );

    localparam logic [1:0] HOLD = 2'b00, SHIFT = 2'b01, LOAD = 2'b10, ROT = 2'b11;

`ifdef UNIV_SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    task automatic step4(input int id, input logic rst, input logic enb, input logic dir,
                         input logic sin, input logic [1:0] modo, input logic [3:0] d,
                         input logic [3:0] eq, input logic eso, input logic [2:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst4 = rst; enb4 = enb; dir4 = dir; sin4 = sin; modo4 = modo; d4 = d;
        e.id = id; e.q = {4'h0, eq}; e.so = eso; e.cnt = {1'b0, ecnt};
        e.empty = (ecnt == 3'd4);
        q4.push_back(e);
    endtask

    task automatic step8(input int id, input logic rst, input logic enb, input logic sin,
                         input logic [1:0] modo, input logic [7:0] d,
                         input logic [7:0] eq, input logic eso, input logic [3:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst8 = rst; enb8 = enb; dir8 = 1'b0; sin8 = sin; modo8 = modo; d8 = d;
        e.id = id; e.q = eq; e.so = eso; e.cnt = ecnt; e.empty = (ecnt == 4'd8);
        q8.push_back(e);
    endtask

    // Monitor: each rising edge the DUTs present a new result; compare #1 later
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                n_checks++;
                if (q_4 == e.q[3:0] && so_4 == e.so && cnt_4 == e.cnt[2:0] && empty_4 == e.empty)
                    n_pass++;
                else
                    $display("FAIL w4_step%0d: got Q=%b S_OUT=%b CNT=%0d EMPTY=%b, want Q=%b S_OUT=%b CNT=%0d EMPTY=%b",
                             e.id, q_4, so_4, cnt_4, empty_4, e.q[3:0], e.so, e.cnt, e.empty);
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                n_checks++;
                if (q_8 == e.q && so_8 == e.so && cnt_8 == e.cnt && empty_8 == e.empty)
                    n_pass++;
                else
                    $display("FAIL w8_step%0d: got Q=%h S_OUT=%b CNT=%0d EMPTY=%b, want Q=%h S_OUT=%b CNT=%0d EMPTY=%b",
                             e.id, q_8, so_8, cnt_8, empty_8, e.q, e.so, e.cnt, e.empty);
            end
        end
    end

    initial begin
        logic [7:0] w8_q   [10];
        logic       w8_so  [10];
        logic [3:0] w8_cnt [10];
        w8_q   = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        w8_so  = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
        w8_cnt = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};

        // reset wins over a load request
        step4( 1, 1, 1, 0, 0, LOAD,  4'hF,    4'b0000, 0, 4);
        step4( 2, 1, 1, 0, 0, LOAD,  4'hF,    4'b0000, 0, 4);
        // load then drain left
        step4( 3, 0, 1, 0, 0, LOAD,  4'b0001, 4'b0001, 0, 0);
        step4( 4, 0, 1, 0, 0, SHIFT, 4'h0,    4'b0010, 0, 1);
        step4( 5, 0, 1, 0, 0, SHIFT, 4'h0,    4'b0100, 0, 2);
        step4( 6, 0, 1, 0, 0, SHIFT, 4'h0,    4'b1000, 0, 3);
        step4( 7, 0, 1, 0, 0, SHIFT, 4'h0,    4'b0000, 1, 4);
        // right shift with S_IN=1, then reload
        step4( 8, 0, 1, 0, 0, LOAD,  4'b0011, 4'b0011, 1, 0);
        step4( 9, 0, 1, 1, 1, SHIFT, 4'h0,    4'b1001, 1, 1);
        step4(10, 0, 1, 1, 1, SHIFT, 4'h0,    4'b1100, 1, 2);
        step4(11, 0, 1, 1, 1, LOAD,  4'b1010, 4'b1010, 1, 0);
        // ENB=0 freezes everything
        step4(12, 0, 0, 1, 0, SHIFT, 4'h0,    4'b1010, 1, 0);
        step4(13, 0, 0, 0, 1, SHIFT, 4'h0,    4'b1010, 1, 0);
        step4(14, 0, 0, 1, 0, LOAD,  4'hF,    4'b1010, 1, 0);
        step4(15, 0, 1, 1, 0, SHIFT, 4'h0,    4'b0101, 0, 1);
        step4(16, 1, 1, 1, 0, SHIFT, 4'h0,    4'b0000, 0, 4);
        // HOLD, then saturation while shifting left with S_IN=1
        step4(17, 0, 1, 0, 0, LOAD,  4'b0110, 4'b0110, 0, 0);
        step4(18, 0, 1, 1, 1, HOLD,  4'hF,    4'b0110, 0, 0);
        step4(19, 0, 1, 0, 1, SHIFT, 4'h0,    4'b1101, 0, 1);
        step4(20, 0, 1, 0, 1, SHIFT, 4'h0,    4'b1011, 1, 2);
        step4(21, 0, 1, 0, 1, SHIFT, 4'h0,    4'b0111, 1, 3);
        step4(22, 0, 1, 0, 1, SHIFT, 4'h0,    4'b1111, 0, 4);
        step4(23, 0, 1, 0, 1, SHIFT, 4'h0,    4'b1111, 1, 4);
        // set S_OUT=0 before rotating so the wrapped bit is visible
        step4(24, 0, 1, 0, 0, LOAD,  4'b1000, 4'b1000, 1, 0);
        step4(25, 0, 1, 1, 0, SHIFT, 4'h0,    4'b0100, 0, 1);
        step4(26, 0, 1, 0, 0, LOAD,  4'b1000, 4'b1000, 0, 0);
        if (ROT_EN) begin
            step4(27, 0, 1, 0, 0, ROT, 4'h0, 4'b0001, 1, 0);
            step4(28, 0, 1, 1, 0, ROT, 4'h0, 4'b1000, 1, 0);
        end else begin
            step4(27, 0, 1, 0, 0, ROT, 4'h0, 4'b1000, 0, 0);
            step4(28, 0, 1, 1, 0, ROT, 4'h0, 4'b1000, 0, 0);
        end
        step4(29, 0, 0, 0, 0, HOLD, 4'h0, ROT_EN ? 4'b1000 : 4'b1000, ROT_EN ? 1'b1 : 1'b0, 0);

        // WIDTH=8: load A5, ten left shifts with S_IN=1
        step8(1, 1, 1, 0, LOAD, 8'hFF, 8'h00, 0, 8);
        step8(2, 0, 1, 0, LOAD, 8'hA5, 8'hA5, 0, 0);
        for (int i = 0; i < 10; i++)
            step8(3 + i, 0, 1, 1, SHIFT, 8'h00, w8_q[i], w8_so[i], w8_cnt[i]);
        step8(13, 0, 0, 0, HOLD, 8'h00, 8'hFF, 1, 8);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q4.size() == 0 && q8.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q4.size(), q8.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
